fir_decim_requant: RTL and testbench

- Output stage placed directly downstream of the transposed-form FIR.
- Each cycle it takes the wide signed FIR result qualified by a sample-valid strobe, and keeps every G_DECIM-th sample.
- Each kept sample is rounded, shifted and saturated to a narrow output word.
- Results go into a 2-entry buffer with a valid/ready interface toward the consumer.
- The FIR has no backpressure, so overruns are flagged, not stalled.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_decim_requant_if.sv | 15 +
 rtl/fir_out_fifo2.sv | 55 +++++
 rtl/fir_decim_requant.sv | 115 +++++++++++
 tb/tb_fir_decim_requant.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constant helpers for the FIR decimating requantizer output stage.
package fir_pkg;

  localparam int OUT_W = 12;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } buf_entry_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Adding half an output LSB before the arithmetic shift gives round-half-up.
  function automatic longint rnd_const(input int shift);
    return longint'(1) << (shift - 1);
  endfunction

endpackage

// File: rtl/fir_decim_requant_if.sv
// Sample-in / result-out handshake bundle between the FIR, this stage and its consumer.
interface fir_decim_requant_if #(
  parameter int G_IN_W  = 23,
  parameter int G_OUT_W = 12
);
  logic                      i_valid;
  logic signed [G_IN_W-1:0]  i_sample;
  logic                      i_ready;
  logic                      o_valid;
  logic signed [G_OUT_W-1:0] o_data;
  logic                      o_sat;

  modport slave  (input i_valid, i_sample, i_ready, output o_valid, o_data, o_sat);
  modport master (output i_valid, i_sample, i_ready, input o_valid, o_data, o_sat);
endinterface

// File: rtl/fir_out_fifo2.sv
// Two-entry FIFO built as head + tail registers; head keeps its last value once drained.
module fir_out_fifo2
  import fir_pkg::*;
#(
  parameter type T_ENTRY = buf_entry_t
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  T_ENTRY     i_data,
  output T_ENTRY     o_head,
  output logic [1:0] o_count,
  output logic       o_full
);

  T_ENTRY     r_head;
  T_ENTRY     r_tail;
  logic [1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the entries are reset too, because the head register drives o_data and must read 0 after reset.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/fir_decim_requant.sv
// Decimate, round, shift and saturate FIR results into a 2-deep valid/ready buffer.
// Optional saturated-sample counter output o_sat_cnt is built when FIR_DECIM_SATCNT_EN is defined.
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int G_IN_W  = 23,
  parameter int G_OUT_W = 12,
  parameter int G_SHIFT = 8,
  parameter int G_DECIM = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fir_decim_requant_if.slave  bus,
  input  logic                i_clr_ovf,
`ifdef FIR_DECIM_SATCNT_EN
  output logic [15:0]         o_sat_cnt,
`endif
  output logic                o_overflow
);

  localparam int PH_W = (G_DECIM > 1) ? $clog2(G_DECIM) : 1;
  localparam logic [PH_W-1:0] C_PH_LAST = PH_W'(G_DECIM - 1);
  localparam logic signed [G_IN_W:0] C_RND = (G_IN_W + 1)'(rnd_const(G_SHIFT));
  localparam logic signed [G_IN_W:0] C_MAX = (G_IN_W + 1)'(sat_max(G_OUT_W));
  localparam logic signed [G_IN_W:0] C_MIN = (G_IN_W + 1)'(sat_min(G_OUT_W));

  logic [PH_W-1:0]          r_phase;
  logic                     r_s1_valid;
  logic signed [G_IN_W-1:0] r_s1_sample;
  logic                     r_ovf;

  logic                     w_keep;
  logic signed [G_IN_W:0]   w_ext;
  logic signed [G_IN_W:0]   w_t;
  logic signed [G_IN_W:0]   w_r;
  buf_entry_t               w_entry;
  buf_entry_t               w_head;
  logic [1:0]               w_count;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_drop;
  logic                     w_push;

  assign w_keep = bus.i_valid && (r_phase == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_sample <= '0;
    end else begin
      if (bus.i_valid) r_phase <= (r_phase == C_PH_LAST) ? '0 : r_phase + PH_W'(1);
      r_s1_valid <= w_keep;
      if (w_keep) r_s1_sample <= bus.i_sample;
    end
  end

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  assign w_ext = {r_s1_sample[G_IN_W-1], r_s1_sample};
  assign w_t   = w_ext + C_RND;
  assign w_r   = w_t >>> G_SHIFT;

  always_comb begin
    w_entry.sat  = 1'b0;
    w_entry.data = w_r[G_OUT_W-1:0];
    if (w_r > C_MAX) begin
      w_entry.sat  = 1'b1;
      w_entry.data = C_MAX[G_OUT_W-1:0];
    end else if (w_r < C_MIN) begin
      w_entry.sat  = 1'b1;
      w_entry.data = C_MIN[G_OUT_W-1:0];
    end
  end

  assign bus.o_valid = (w_count != 2'd0);
  assign w_pop       = bus.o_valid && bus.i_ready;
  assign w_drop      = r_s1_valid && w_full && !w_pop;
  assign w_push      = r_s1_valid && !w_drop;

  fir_out_fifo2 #(.T_ENTRY(buf_entry_t)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  assign bus.o_data = w_head.data;
  assign bus.o_sat  = w_head.sat;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (i_clr_ovf) r_ovf <= 1'b0;
  end

  assign o_overflow = r_ovf;

`ifdef FIR_DECIM_SATCNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_sat_cnt <= '0;
    else if (i_clr_ovf) r_sat_cnt <= '0;
    else if (w_push && w_entry.sat && (r_sat_cnt != 16'hFFFF)) r_sat_cnt <= r_sat_cnt + 16'd1;
  end

  assign o_sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench: a G_DECIM=4 instance for decimation/arithmetic, a G_DECIM=1 instance for buffering.
module tb_fir_decim_requant;

  logic clk;
  logic rst_n;
  logic clr;
  logic ovf4;
  logic ovf1;
`ifdef FIR_DECIM_SATCNT_EN
  logic [15:0] sat_cnt4;
  logic [15:0] sat_cnt1;
`endif
  int checks = 0;
  int errors = 0;

  fir_decim_requant_if #(.G_IN_W(23), .G_OUT_W(12)) bus4 ();
  fir_decim_requant_if #(.G_IN_W(23), .G_OUT_W(12)) bus1 ();

  fir_decim_requant #(.G_IN_W(23), .G_OUT_W(12), .G_SHIFT(8), .G_DECIM(4)) dut4 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus4.slave),
    .i_clr_ovf  (clr),
`ifdef FIR_DECIM_SATCNT_EN
    .o_sat_cnt  (sat_cnt4),
`endif
    .o_overflow (ovf4)
  );

  fir_decim_requant #(.G_IN_W(23), .G_OUT_W(12), .G_SHIFT(8), .G_DECIM(1)) dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus1.slave),
    .i_clr_ovf  (clr),
`ifdef FIR_DECIM_SATCNT_EN
    .o_sat_cnt  (sat_cnt1),
`endif
    .o_overflow (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Keep x at phase 0 on dut4, follow with three skipped samples, check result 2 cycles later.
  task automatic keep4(input string tag, input logic signed [22:0] x,
                       input logic signed [31:0] exp_d, input logic exp_s);
    bus4.i_valid  = 1'b1;
    bus4.i_sample = x;
    step();
    chk({tag, "_lat1"}, bus4.o_valid, 0);
    bus4.i_sample = 23'sd0;
    step();
    chk({tag, "_valid"}, bus4.o_valid, 1);
    chk({tag, "_data"}, bus4.o_data, exp_d);
    chk({tag, "_sat"}, bus4.o_sat, exp_s);
    step();
    step();
    bus4.i_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    bus4.i_valid = 1'b0; bus4.i_sample = '0; bus4.i_ready = 1'b1;
    bus1.i_valid = 1'b0; bus1.i_sample = '0; bus1.i_ready = 1'b0;
    step();
    step();
    chk("rst_valid4", bus4.o_valid, 0);
    chk("rst_data4", bus4.o_data, 0);
    chk("rst_sat4", bus4.o_sat, 0);
    chk("rst_ovf4", ovf4, 0);
    chk("rst_valid1", bus1.o_valid, 0);
    chk("rst_ovf1", ovf1, 0);
    rst_n = 1'b1;

    // Samples 1..8: only 1 and 5 are kept, each visible two cycles after input.
    for (int k = 1; k <= 8; k++) begin
      bus4.i_valid  = 1'b1;
      bus4.i_sample = 23'(k);
      step();
      chk("dec_valid", bus4.o_valid, (k == 2 || k == 6) ? 1 : 0);
      if (k == 2 || k == 6) chk("dec_data", bus4.o_data, 0);
    end
    bus4.i_valid = 1'b0;

    keep4("p1000", 23'sd1000, 4, 1'b0);
    keep4("m1000", -23'sd1000, -4, 1'b0);
    keep4("p128", 23'sd128, 1, 1'b0);
    keep4("p127", 23'sd127, 0, 1'b0);
    keep4("satmax", 23'sd4194303, 2047, 1'b1);
    keep4("satmin", -23'sd4194304, -2048, 1'b1);

    // dut1 with consumer stalled: 256 and 512 fill the buffer, 768 is dropped.
    bus1.i_valid = 1'b1;
    bus1.i_sample = 23'sd256; step();
    bus1.i_sample = 23'sd512; step();
    chk("ovr_first_valid", bus1.o_valid, 1);
    chk("ovr_first_data", bus1.o_data, 1);
    bus1.i_sample = 23'sd768; step();
    bus1.i_valid = 1'b0;
    chk("ovr_no_flag_yet", ovf1, 0);
    step();
    chk("ovr_flag", ovf1, 1);
    chk("ovr_head_stable", bus1.o_data, 1);
    bus1.i_ready = 1'b1;
    step();
    chk("ovr_pop1_valid", bus1.o_valid, 1);
    chk("ovr_pop1_data", bus1.o_data, 2);
    step();
    chk("ovr_empty_valid", bus1.o_valid, 0);
    chk("ovr_empty_hold", bus1.o_data, 2);
    chk("ovr_sticky", ovf1, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovr_cleared", ovf1, 0);

    // Full buffer with a pop and a push in the same cycle: nothing is dropped.
    bus1.i_ready = 1'b0;
    bus1.i_valid = 1'b1;
    bus1.i_sample = 23'sd256; step();
    bus1.i_sample = 23'sd512; step();
    bus1.i_sample = 23'sd768; step();
    bus1.i_valid = 1'b0;
    bus1.i_ready = 1'b1;
    chk("pp_full_head", bus1.o_data, 1);
    step();
    chk("pp_no_ovf", ovf1, 0);
    chk("pp_valid", bus1.o_valid, 1);
    chk("pp_head2", bus1.o_data, 2);
    step();
    chk("pp_head3", bus1.o_data, 3);
    chk("pp_no_ovf2", ovf1, 0);
    step();
    chk("pp_drained", bus1.o_valid, 0);

    // Reset with two buffered, one in flight and overflow set; dut4 phase left at 1.
    bus1.i_ready = 1'b0;
    bus1.i_valid = 1'b1;
    bus4.i_valid = 1'b1; bus4.i_sample = 23'sd0;
    bus1.i_sample = 23'sd256; step();
    bus4.i_valid = 1'b0;
    bus1.i_sample = 23'sd512; step();
    bus1.i_sample = 23'sd768; step();
    bus1.i_sample = 23'sd1024; step();
    chk("mrst_pre_ovf", ovf1, 1);
    rst_n = 1'b0;
    bus1.i_valid = 1'b0;
    step();
    chk("mrst_valid1", bus1.o_valid, 0);
    chk("mrst_data1", bus1.o_data, 0);
    chk("mrst_ovf1", ovf1, 0);
    chk("mrst_valid4", bus4.o_valid, 0);
    rst_n = 1'b1;
    bus4.i_valid = 1'b1; bus4.i_sample = 23'sd1000;
    bus1.i_valid = 1'b1; bus1.i_sample = 23'sd1280; bus1.i_ready = 1'b1;
    step();
    bus4.i_valid = 1'b0;
    bus1.i_valid = 1'b0;
    chk("post_lat4", bus4.o_valid, 0);
    step();
    chk("post_valid4", bus4.o_valid, 1);
    chk("post_data4", bus4.o_data, 4);
    chk("post_valid1", bus1.o_valid, 1);
    chk("post_data1", bus1.o_data, 5);
    chk("post_ovf1", ovf1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
